// File: rtl/contador_descendente.sv
// Down-counter with parallel load, start strobe and a one-cycle FINAL pulse.
// Define CONTADOR_DESC_RECARGA_EN to reload from the last loaded value after FINAL (periodic mode).
module contador_descendente #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] valor,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             cero
);

    typedef enum logic [1:0] {
        IDLE,
        COUNTING,
        FINAL
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t next_state;

`ifdef CONTADOR_DESC_RECARGA_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
        end else if (load) begin
            reload <= valor;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load overrides every state; the q<=1 test also guards against ever decrementing past zero.
    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        next_state = (q != '0) ? COUNTING : FINAL;
                    end
                end
                COUNTING: begin
                    if (enable && (q <= ONE)) begin
                        next_state = FINAL;
                    end
                end
                FINAL: begin
`ifdef CONTADOR_DESC_RECARGA_EN
                    next_state = (reload != '0) ? COUNTING : IDLE;
`else
                    next_state = IDLE;
`endif
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= valor;
        end else begin
            case (state)
                COUNTING: begin
                    if (enable && (q != '0)) begin
                        q <= q - ONE;
                    end
                end
`ifdef CONTADOR_DESC_RECARGA_EN
                FINAL: q <= reload;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state == COUNTING);
        done = (state == FINAL);
    end

    assign cero = (q == '0);

endmodule

// File: doc/contador_descendente.md
CONTADOR_DESCENDENTE -- requirements
Module: contador_descendente

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: count-qualify; decrement occurs only when high in COUNTING.
REQ-005 SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-006 SHALL have port valor, input, WIDTH bits: parallel-load value.
REQ-007 SHALL have port start, input, 1 bit: start-countdown strobe.
REQ-008 SHALL have port q, output, WIDTH bits: registered counter value.
REQ-009 SHALL have port busy, output, 1 bit: high while in COUNTING.
REQ-010 SHALL have port done, output, 1 bit: high for exactly one cycle in FINAL.
REQ-011 SHALL have port cero, output, 1 bit: combinational (q == 0).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, COUNTING, FINAL.
REQ-013 Priority every cycle SHALL be: reset > load > state action.
REQ-014 load=1 in any state SHALL set q<=valor, capture valor into an internal reload register, and force IDLE next; start that cycle ignored.
REQ-015 IDLE, start=1, q!=0: SHALL enter COUNTING next cycle; q unchanged on the start edge.
REQ-016 IDLE, start=1, q==0: SHALL enter FINAL directly (done pulse, no decrement).
REQ-017 COUNTING, enable=1: q<=q-1; if q==1, next state FINAL (q becomes 0 same edge).
REQ-018 COUNTING, enable=0: q and state SHALL hold.
REQ-019 start in COUNTING or FINAL SHALL be ignored.
REQ-020 q SHALL never wrap below 0 (no 0 -> all-ones transition in any mode).
REQ-021 FINAL SHALL last one cycle; next-state and q per REQ-026/REQ-027.
REQ-022 Latency: from start edge with q=N (N>0) and enable held high, done SHALL assert on edge N+1 after start and busy SHALL be high for N cycles.
REQ-023 busy and done SHALL be decoded directly from the state register (glitch-free, registered).

Reset
REQ-024 reset=1 SHALL immediately, without clk, force: q=0, reload register=0, state IDLE, busy=0, done=0, cero=1.
REQ-025 Reset asserted mid-count SHALL abort the countdown; after release the block SHALL wait in IDLE for load/start.

Configuration
REQ-026 Without macro CONTADOR_DESC_RECARGA_EN: FINAL SHALL go to IDLE with q=0 held.
REQ-027 With CONTADOR_DESC_RECARGA_EN defined: FINAL SHALL set q<=reload register and go to COUNTING if reload register != 0, else IDLE; periodic countdown continues until load or reset.

Verification
REQ-028 WIDTH=4, reset pulse mid-count with q=5 -> q=0, busy=0, done=0, cero=1 asynchronously, before the next clk edge.
REQ-029 load valor=3, then start, enable=1 -> q 3,3,2,1,0; busy high 3 cycles; done high one cycle on edge 4 after start; then IDLE, q=0 (macro off).
REQ-030 load 5, start, enable toggled 1,0,1,0... -> q decrements only on enable=1 cycles; done after 5 enabled cycles; q never below 0.
REQ-031 start with q=0 -> done one cycle, busy never high; load=1 with start=1 same cycle -> q=valor, state IDLE, no count.
REQ-032 macro on, load 2, start, enable=1 -> q 2,1,0(done),2,1,0(done)... repeating; load valor=0 during count -> IDLE, q=0, counting stops.
